enigma_keyer: RTL and testbench
===============================

# enigma_keyer

Stream front-end/back-end for the `enigma` letter pipeline. Accepts ASCII characters over a valid/ready stream and converts letters to one-hot. Drives the engine with per-letter rotor positions from an odometer-style stepping counter. Recaptures the engine's fixed-latency result into a small FIFO and returns ASCII characters over a second valid/ready stream with backpressure. It is the initiating end of the engine's letter/position interface; encryption and decryption use the same path because the machine is reciprocal.

## Interface
Parameters:
- `LATENCY`, default 4: engine edges from input sample to `output_reg` update, plus one. Must equal `enigma_pkg::ENGINE_LATENCY`.
- `FIFO_DEPTH`, default 8: result FIFO entries. Power of two, ≥ `LATENCY`. Must be ≥ `LATENCY+1` for 1 char/cycle throughput.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: input character valid.
- `s_ready` out 1: input character accepted when high with `s_valid`.
- `s_char` in 8: ASCII input character.
- `cfg_load` in 1: load start positions (single-cycle pulse).
- `cfg_n1`, `cfg_n2`, `cfg_n3` in 5 each: start positions 0..25.
- `e_letter` out 26: one-hot letter to the engine. All-zero when no letter is accepted.
- `e_n1`, `e_n2`, `e_n3` out 5 each: rotor positions to the engine.
- `e_result` in 26: engine output letter.
- `m_valid` out 1: output character valid.
- `m_ready` in 1: output sink ready.
- `m_char` out 8: ASCII output character.

## Operation
- **Character classification:**
  - 'A'..'Z' (0x41–0x5A) is a letter.
  - 'a'..'z' is folded to uppercase, then treated as a letter.
  - Anything else is a bypass character.
- **Accept:** `s_valid && s_ready` at a rising edge.
- **Combinational outputs on an accepted letter:**
  - `e_letter = 1 << (char-'A')`.
  - `e_n1/2/3` = current positions.
- **When not accepting a letter:**
  - `e_letter = 0`.
  - `e_n*` still show current positions.
- **Stepping:** occurs only on an accepted letter.
  - `n1 <= (n1==25)?0:n1+1`.
  - When n1 wraps, n2 steps the same way.
  - When n2 wraps, n3 steps the same way.
  - n3 wraps 25→0 with no carry out.
- **cfg_load:**
  - Loads `n1..n3` from `cfg_n*` and forces `s_ready=0` that cycle.
  - Out-of-range values (26–31) are loaded modulo 26.
- **Tag shift register:** `LATENCY` entries of {valid, bypass, char}.
  - One entry is pushed every cycle: valid=accept.
  - The entry at stage `LATENCY-1` aligns with `e_result`.
- **Retire:** a valid tag writes into the FIFO.
  - Letter: writes `onehot_to_ascii(e_result)`.
  - Bypass: writes the stored char unchanged.
  - A non-one-hot `e_result` on a letter tag is written as 0x3F ('?').
- **Credit:** `s_ready = !cfg_load && (inflight + fifo_count < FIFO_DEPTH)`.
  - `inflight` is the number of valid tags.
  - This guarantees the FIFO never overflows; a pop in the same cycle is not credited.
- **FIFO:**
  - `m_valid = !empty`, `m_char` = head entry.
  - Pop on `m_valid && m_ready`.
  - Simultaneous push and pop keeps the count and preserves order.
- **Ordering:** output order always equals input order, including bypass characters.

## Timing
- **Reset values:**
  - `s_ready=0` while `rst_n` is low, 1 in the first cycle after release (FIFO empty).
  - `m_valid=0`, `m_char=0`, `e_letter=0`, `e_n*=0`.
  - Positions 0/0/0, all tags invalid, FIFO empty.
- **Reset mid-operation:** in-flight and buffered characters are discarded. Engine residue is ignored because the tags are invalid.
- **Paths:** `s_char`→`e_letter` is combinational; the engine registers it on the accepting edge E.
- **Latency:**
  - The engine result is visible after edge E+3.
  - The FIFO writes at edge E+4.
  - `m_valid` is asserted in the cycle after E+4, i.e. 5 cycles after accept with `LATENCY=4`.
- **Throughput:** 1 char/cycle with `FIFO_DEPTH≥5` and `m_ready` held high.
- **Simultaneous `cfg_load` and `s_valid`:** the load wins and the char waits. The next accepted letter uses the loaded positions.

## Configuration
- **`ENIGMA_KEYER_BYPASS_EN` defined:** non-letters pass through in order as described above.
- **Undefined:**
  - Non-letters are accepted (consumed) but produce no output.
  - They push no tag, do not step the rotors and do not consume credit.
  - The tag `bypass` and `char` fields are removed.

## Structure
- **`enigma_pkg`:**
  - `ALPHABET=26`, `ENGINE_LATENCY=4`.
  - `letter_t` (logic [25:0]), `pos_t` (logic [4:0]).
  - Functions `ascii_to_onehot`, `onehot_to_ascii`, `step_pos`.
- **Sub-module `enigma_keyer_fifo`:** parameterized synchronous FIFO (push, pop, full, empty, count). The top level holds the classifier, stepping counter, tag pipe and credit logic.

## Test plan
- **Reset defaults:** after reset, hold `s_valid=0` for 10 cycles → `m_valid=0`, `e_letter=0`, `e_n*=0/0/0`.
- **Single letter and stepping:** load 25/25/3, send 'a' → `e_letter=0x0000001`, `e_n*=25/25/3`. Positions become 0/0/4. `m_valid` rises 5 cycles after accept with the golden-model char.
- **Round trip:** stream "HELLO WORLD" from 0/0/0 with `m_ready=1` at 1 char/cycle, reload 0/0/0, feed the ciphertext back → plaintext is recovered. The space is bypassed, and positions reach 10/0/0 after the letters.
- **Backpressure:** `m_ready=0` with a continuous `s_valid`.
  - `s_ready` falls after 8 accepts (DEPTH=8), with no overflow and no loss.
  - Releasing `m_ready` drains all 8 in order.
- **Load/accept collision:** `cfg_load` and `s_valid` in the same cycle → char stalls one cycle and is encrypted with the loaded positions.
- **Mid-stream reset and fault:**
  - Assert `rst_n` with 3 chars in flight → no output after release.
  - Force a two-hot `e_result` on a letter tag → `m_char=0x3F`.
  - With the macro undefined, '!' produces no output and no step.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and letter/position helpers for the enigma keyer.
// The tag layout depends on ENIGMA_KEYER_BYPASS_EN (bypass class and char fields).
package enigma_pkg;

  localparam int ALPHABET       = 26;
  localparam int ENGINE_LATENCY = 4;

  typedef logic [ALPHABET-1:0] letter_t;
  typedef logic [4:0]          pos_t;
  typedef logic [7:0]          char_t;

  typedef enum logic {
    CLASS_BYPASS = 1'b0,
    CLASS_LETTER = 1'b1
  } char_class_t;

  typedef struct packed {
    logic        valid;
`ifdef ENIGMA_KEYER_BYPASS_EN
    char_class_t cls;
    char_t       ch;
`endif
  } tag_t;

  function automatic char_t fold_upper(input char_t c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  // Zero for anything that is not a letter after case folding.
  function automatic letter_t ascii_to_onehot(input char_t c);
    char_t u;
    u = fold_upper(c);
    if (u >= 8'h41 && u <= 8'h5A) return letter_t'(1) << (u - 8'h41);
    return '0;
  endfunction

  // A result that is not exactly one-hot comes back as '?'.
  function automatic char_t onehot_to_ascii(input letter_t l);
    char_t ch;
    int    hits;
    ch   = 8'h3F;
    hits = 0;
    for (int i = 0; i < ALPHABET; i++) begin
      if (l[i]) begin
        hits++;
        ch = 8'h41 + 8'(i);
      end
    end
    return (hits == 1) ? ch : 8'h3F;
  endfunction

  function automatic pos_t step_pos(input pos_t p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic pos_t load_pos(input pos_t p);
    return (p >= 5'd26) ? p - 5'd26 : p;
  endfunction

endpackage

// File: rtl/enigma_keyer_fifo.sv
// Synchronous result FIFO for the enigma keyer; DEPTH must be a power of two.
// Head entry reads as zero while the FIFO is empty.
module enigma_keyer_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/enigma_keyer.sv
// ASCII stream front/back end for the enigma letter pipeline with rotor stepping.
// Define ENIGMA_KEYER_BYPASS_EN to pass non-letters through in order; otherwise they are dropped.
module enigma_keyer
  import enigma_pkg::*;
#(
  parameter int LATENCY    = ENGINE_LATENCY,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_char,
  input  logic        cfg_load,
  input  logic [4:0]  cfg_n1,
  input  logic [4:0]  cfg_n2,
  input  logic [4:0]  cfg_n3,
  output logic [25:0] e_letter,
  output logic [4:0]  e_n1,
  output logic [4:0]  e_n2,
  output logic [4:0]  e_n3,
  input  logic [25:0] e_result,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_char
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);

  letter_t       in_onehot;
  logic          is_letter;
  logic          accept;
  logic          letter_accept;
  logic          push_tag;
  logic          retire;
  pos_t          n1, n2, n3;
  tag_t          new_tag;
  tag_t          tags [LATENCY];
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  char_t         fifo_din;
  char_t         fifo_dout;

  assign in_onehot = ascii_to_onehot(s_char);
  assign is_letter = |in_onehot;

  // Credit covers every tag still in the engine, so a retire always finds room.
  assign s_ready = rst_n && !cfg_load &&
                   ((int'(inflight) + int'(fifo_count)) < FIFO_DEPTH);
  assign accept        = s_valid && s_ready;
  assign letter_accept = accept && is_letter;

  assign e_letter = letter_accept ? in_onehot : '0;
  assign e_n1     = n1;
  assign e_n2     = n2;
  assign e_n3     = n3;

  always_comb begin
    new_tag = '0;
`ifdef ENIGMA_KEYER_BYPASS_EN
    push_tag    = accept;
    new_tag.cls = is_letter ? CLASS_LETTER : CLASS_BYPASS;
    new_tag.ch  = s_char;
`else
    push_tag    = letter_accept;
`endif
    new_tag.valid = push_tag;
  end

  // Odometer stepping: n1 every letter, carries ripple on wrap, n3 has no carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n1 <= '0;
      n2 <= '0;
      n3 <= '0;
    end else if (cfg_load) begin
      n1 <= load_pos(cfg_n1);
      n2 <= load_pos(cfg_n2);
      n3 <= load_pos(cfg_n3);
    end else if (letter_accept) begin
      n1 <= step_pos(n1);
      if (n1 == 5'd25) begin
        n2 <= step_pos(n2);
        if (n2 == 5'd25) n3 <= step_pos(n3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= new_tag;
      for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  assign retire = tags[LATENCY-1].valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (push_tag && !retire) begin
      inflight <= inflight + IW'(1);
    end else if (retire && !push_tag) begin
      inflight <= inflight - IW'(1);
    end
  end

  always_comb begin
    fifo_din = onehot_to_ascii(e_result);
`ifdef ENIGMA_KEYER_BYPASS_EN
    if (tags[LATENCY-1].cls == CLASS_BYPASS) fifo_din = tags[LATENCY-1].ch;
`endif
  end

  assign fifo_push = retire && !fifo_full;
  assign fifo_pop  = m_valid && m_ready;
  assign m_valid   = !fifo_empty;
  assign m_char    = fifo_dout;

  enigma_keyer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_enigma_keyer.sv
// Directed bench for enigma_keyer with a toy reciprocal engine model in the loop.
// Non-letter expectations follow ENIGMA_KEYER_BYPASS_EN.
module tb_enigma_keyer;

`ifdef ENIGMA_KEYER_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_char = 8'h00;
  logic        cfg_load = 1'b0;
  logic [4:0]  cfg_n1 = 5'd0;
  logic [4:0]  cfg_n2 = 5'd0;
  logic [4:0]  cfg_n3 = 5'd0;
  logic [25:0] e_letter;
  logic [4:0]  e_n1, e_n2, e_n3;
  logic [25:0] e_result = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_char;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic inject_fault = 1'b0;
  logic [25:0] eng_p0 = '0, eng_p1 = '0, eng_p2 = '0;
  logic [7:0] rx_q [$];

  enigma_keyer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_char   (s_char),
    .cfg_load (cfg_load),
    .cfg_n1   (cfg_n1),
    .cfg_n2   (cfg_n2),
    .cfg_n3   (cfg_n3),
    .e_letter (e_letter),
    .e_n1     (e_n1),
    .e_n2     (e_n2),
    .e_n3     (e_n3),
    .e_result (e_result),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_char   (m_char)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Toy reciprocal engine: y = (n1 + 3*n2 + 7*n3 + 1 - x) mod 26.
  function automatic logic [25:0] engine_f(input logic [25:0] l, input logic [4:0] a,
                                           input logic [4:0] b, input logic [4:0] c);
    int x, s;
    x = -1;
    for (int i = 0; i < 26; i++) if (l[i]) x = i;
    if (x < 0) return '0;
    s = (int'(a) + 3 * int'(b) + 7 * int'(c) + 1) % 26;
    return 26'(1) << ((s + 26 - x) % 26);
  endfunction

  // Sample on E, result register updates on E+3.
  always @(posedge clk) begin
    eng_p0   <= engine_f(e_letter, e_n1, e_n2, e_n3);
    eng_p1   <= eng_p0;
    eng_p2   <= eng_p1;
    e_result <= inject_fault ? 26'h3 : eng_p2;
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) rx_q.push_back(m_char);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c, input string tag);
    int budget;
    budget = 200;
    s_valid = 1'b1;
    s_char  = c;
    @(negedge clk);
    while (!s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!s_ready) checkOutput({tag, " accept timeout"}, 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic cfgLoad(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    cfg_n1 = a; cfg_n2 = b; cfg_n3 = c;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic waitRx(input int n, input string tag);
    int budget;
    budget = 100;
    while (rx_q.size() < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checkOutput({tag, " count"}, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string src, plain, bp_src, bp_exp;
    logic [7:0] ct [$];
    int t0, acc;

    // Reset defaults
    @(negedge clk);
    checkOutput("rst s_ready", 32'(s_ready), 0);
    checkOutput("rst m_valid", 32'(m_valid), 0);
    checkOutput("rst m_char", 32'(m_char), 0);
    checkOutput("rst e_letter", 32'(e_letter), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("idle m_valid", 32'(m_valid), 0);
    end
    checkOutput("idle e_letter", 32'(e_letter), 0);
    checkOutput("idle e_n1", 32'(e_n1), 0);
    checkOutput("idle e_n2", 32'(e_n2), 0);
    checkOutput("idle e_n3", 32'(e_n3), 0);
    checkOutput("idle s_ready", 32'(s_ready), 1);
    @(posedge clk); #1;

    // Out-of-range loads wrap modulo 26
    cfgLoad(5'd30, 5'd27, 5'd26);
    @(negedge clk);
    checkOutput("mod e_n1", 32'(e_n1), 4);
    checkOutput("mod e_n2", 32'(e_n2), 1);
    checkOutput("mod e_n3", 32'(e_n3), 0);
    @(posedge clk); #1;

    // Single lowercase letter with full carry ripple
    m_ready = 1'b0;
    cfgLoad(5'd25, 5'd25, 5'd3);
    s_valid = 1'b1;
    s_char  = 8'h61;
    @(negedge clk);
    checkOutput("one e_letter", 32'(e_letter), 1);
    checkOutput("one e_n1", 32'(e_n1), 25);
    checkOutput("one e_n2", 32'(e_n2), 25);
    checkOutput("one e_n3", 32'(e_n3), 3);
    checkOutput("one s_ready", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("one step n1", 32'(e_n1), 0);
        checkOutput("one step n2", 32'(e_n2), 0);
        checkOutput("one step n3", 32'(e_n3), 4);
        checkOutput("one idle e_letter", 32'(e_letter), 0);
      end
      if (k == 4) checkOutput("one m_valid early", 32'(m_valid), 0);
      if (k == 5) begin
        checkOutput("one m_valid", 32'(m_valid), 1);
        checkOutput("one m_char", 32'(m_char), 32'h53);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    waitRx(1, "one drain");
    rx_q.delete();

    // Round trip at one char per cycle
    src   = "HELLO WORLD";
    plain = "HELLOWORLD";
    if (BYP != 0) plain = "HELLO WORLD";
    cfgLoad(5'd0, 5'd0, 5'd0);
    t0 = cyc;
    for (int i = 0; i < src.len(); i++) applyStimulus(src[i], "rt enc");
    checkOutput("rt cycles", 32'(cyc - t0), 32'(src.len()));
    @(negedge clk);
    checkOutput("rt n1", 32'(e_n1), 10);
    checkOutput("rt n2", 32'(e_n2), 0);
    checkOutput("rt n3", 32'(e_n3), 0);
    @(posedge clk); #1;
    waitRx(plain.len(), "rt enc");
    checkOutput("rt ct0", 32'(rx_q[0]), 32'h55);
    checkOutput("rt ct1", 32'(rx_q[1]), 32'h59);
    if (BYP != 0) checkOutput("rt ct space", 32'(rx_q[5]), 32'h20);
    ct = rx_q;
    rx_q.delete();
    cfgLoad(5'd0, 5'd0, 5'd0);
    for (int i = 0; i < ct.size(); i++) applyStimulus(ct[i], "rt dec");
    waitRx(plain.len(), "rt dec");
    for (int i = 0; i < plain.len(); i++) checkOutput($sformatf("rt pt%0d", i), 32'(rx_q[i]), 32'(plain[i]));
    rx_q.delete();

    // Backpressure: credit stops at FIFO depth, then drains in order
    m_ready = 1'b0;
    cfgLoad(5'd0, 5'd0, 5'd0);
    bp_src = "ADGJMPSV";
    bp_exp = "BZXVTRPN";
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1;
      s_char  = (acc < 8) ? bp_src[acc] : 8'h5A;
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    checkOutput("bp accepts", 32'(acc), 8);
    @(negedge clk);
    checkOutput("bp s_ready", 32'(s_ready), 0);
    checkOutput("bp m_valid", 32'(m_valid), 1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    waitRx(8, "bp drain");
    for (int i = 0; i < 8; i++) checkOutput($sformatf("bp out%0d", i), 32'(rx_q[i]), 32'(bp_exp[i]));
    idle(3);
    checkOutput("bp empty", 32'(m_valid), 0);
    checkOutput("bp extra", 32'(rx_q.size()), 8);
    rx_q.delete();

    // Load and valid in the same cycle: load wins, char uses loaded positions
    cfg_n1 = 5'd5; cfg_n2 = 5'd0; cfg_n3 = 5'd0;
    cfg_load = 1'b1;
    s_valid  = 1'b1;
    s_char   = 8'h41;
    @(negedge clk);
    checkOutput("col s_ready", 32'(s_ready), 0);
    checkOutput("col e_letter hold", 32'(e_letter), 0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    @(negedge clk);
    checkOutput("col e_n1", 32'(e_n1), 5);
    checkOutput("col e_letter", 32'(e_letter), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    waitRx(1, "col");
    checkOutput("col char", 32'(rx_q[0]), 32'h47);
    rx_q.delete();

    // Reset with three chars in flight discards them
    applyStimulus(8'h41, "mid");
    applyStimulus(8'h42, "mid");
    applyStimulus(8'h43, "mid");
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid s_ready", 32'(s_ready), 0);
    checkOutput("mid m_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(10);
    checkOutput("mid rx", 32'(rx_q.size()), 0);
    checkOutput("mid e_n1", 32'(e_n1), 0);

    // Two-hot engine result on a letter tag
    inject_fault = 1'b1;
    applyStimulus(8'h41, "fault");
    waitRx(1, "fault");
    checkOutput("fault char", 32'(rx_q[0]), 32'h3F);
    inject_fault = 1'b0;
    idle(2);
    rx_q.delete();

    // Non-letter: never steps; output only when bypass is built in
    cfgLoad(5'd0, 5'd0, 5'd0);
    applyStimulus(8'h21, "bang");
    @(negedge clk);
    checkOutput("bang e_n1", 32'(e_n1), 0);
    checkOutput("bang e_letter", 32'(e_letter), 0);
    @(posedge clk); #1;
    idle(10);
    checkOutput("bang rx", 32'(rx_q.size()), 32'(BYP));
    checkOutput("bang char", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'd0, (BYP != 0) ? 32'h21 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
